id_ex_latch: RTL and testbench

ID_EX_LATCH -- requirements
Module: id_ex_latch

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/id_ex_latch.sv | 136 +++++++++++++
 tb/tb_id_ex_latch.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the ID/EX latch control encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [REG_W-1:0]   regbits_t;
    typedef logic [ALUOP_W-1:0] aluop_t;

    // Per-edge action of the ID/EX pipeline latch
    typedef enum logic [1:0] {
        LOAD,
        HOLD,
        BUBBLE
    } latch_ctl_e;

endpackage

// File: rtl/id_ex_latch.sv
// ID/EX pipeline latch with load-use hazard detection, flush/hold handling,
// sticky halt tracking and a saturating bubble counter.
module id_ex_latch
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  word_t            id_pc,
    input  word_t            id_rdat1,
    input  word_t            id_rdat2,
    input  word_t            id_imm,
    input  regbits_t         id_rs1,
    input  regbits_t         id_rs2,
    input  regbits_t         id_rd,
    input  aluop_t           id_aluop,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_halt,
    output logic             ex_valid,
    output word_t            ex_pc,
    output word_t            ex_rdat1,
    output word_t            ex_rdat2,
    output word_t            ex_imm,
    output regbits_t         ex_rs1,
    output regbits_t         ex_rs2,
    output regbits_t         ex_rd,
    output aluop_t           ex_aluop,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_halt,
    output logic             stall_req,
    output logic             halt_seen,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic       r_flush_pend;
    logic       w_stall;
    logic       w_cnt_inc;
    latch_ctl_e w_ctl;

    // Load-use hazard and per-edge action: hold > flush > halt > stall > load
    always_comb begin
        w_ctl     = LOAD;
        w_cnt_inc = 1'b0;
        w_stall   = ex_valid & ex_memread & (ex_rd != '0)
                  & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid;
        stall_req = w_stall;
        if (hold) begin
            w_ctl = HOLD;
        end else if (flush | r_flush_pend) begin
            w_ctl     = BUBBLE;
            w_cnt_inc = 1'b1;
        end else if (halt_seen) begin
            w_ctl = BUBBLE;
        end else if (w_stall) begin
            w_ctl     = BUBBLE;
            w_cnt_inc = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_flush_pend <= 1'b0;
            halt_seen    <= 1'b0;
            bubble_cnt   <= '0;
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rdat1     <= '0;
            ex_rdat2     <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_aluop     <= '0;
            ex_alusrc    <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_halt      <= 1'b0;
        end else begin
            // A flush seen under hold is remembered until the latch can act on it
            r_flush_pend <= hold ? (r_flush_pend | flush) : 1'b0;
            if (w_cnt_inc && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            case (w_ctl)
                LOAD: begin
                    ex_valid    <= id_valid;
                    ex_pc       <= id_pc;
                    ex_rdat1    <= id_rdat1;
                    ex_rdat2    <= id_rdat2;
                    ex_imm      <= id_imm;
                    ex_rs1      <= id_rs1;
                    ex_rs2      <= id_rs2;
                    ex_rd       <= id_rd;
                    ex_aluop    <= id_aluop;
                    ex_alusrc   <= id_alusrc;
                    ex_regwrite <= id_regwrite & id_valid;
                    ex_memread  <= id_memread  & id_valid;
                    ex_memwrite <= id_memwrite & id_valid;
                    ex_halt     <= id_halt     & id_valid;
                    if (id_valid & id_halt) begin
                        halt_seen <= 1'b1;
                    end
                end
                BUBBLE: begin
                    ex_valid    <= 1'b0;
                    ex_pc       <= '0;
                    ex_rdat1    <= '0;
                    ex_rdat2    <= '0;
                    ex_imm      <= '0;
                    ex_rs1      <= '0;
                    ex_rs2      <= '0;
                    ex_rd       <= '0;
                    ex_aluop    <= '0;
                    ex_alusrc   <= 1'b0;
                    ex_regwrite <= 1'b0;
                    ex_memread  <= 1'b0;
                    ex_memwrite <= 1'b0;
                    ex_halt     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_latch.sv
// Scoreboard bench for id_ex_latch: expected EX-stage snapshots are queued as
// stimulus is driven and compared one cycle later.
module tb_id_ex_latch;
    import cpu_types_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;
    localparam int unsigned INSTR_W = 153;
    localparam int unsigned OBS_W   = INSTR_W + 1 + CNT_W;

    typedef logic [OBS_W-1:0] obs_t;
    typedef struct packed {
        logic     valid;
        word_t    pc;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        regbits_t rs1;
        regbits_t rs2;
        regbits_t rd;
        aluop_t   aluop;
        logic     alusrc;
        logic     regwrite;
        logic     memread;
        logic     memwrite;
        logic     halt;
    } instr_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             hold, flush, id_valid;
    word_t            id_pc, id_rdat1, id_rdat2, id_imm;
    regbits_t         id_rs1, id_rs2, id_rd;
    aluop_t           id_aluop;
    logic             id_alusrc, id_regwrite, id_memread, id_memwrite, id_halt;
    logic             ex_valid;
    word_t            ex_pc, ex_rdat1, ex_rdat2, ex_imm;
    regbits_t         ex_rs1, ex_rs2, ex_rd;
    aluop_t           ex_aluop;
    logic             ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_halt;
    logic             stall_req, halt_seen;
    logic [CNT_W-1:0] bubble_cnt;

    int   n_cmp, n_bad;
    int   exp_cnt;
    logic exp_hs;
    obs_t sb[$];
    obs_t last_exp;
    obs_t got, want;

    id_ex_latch #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_halt(id_halt),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_halt(ex_halt),
        .stall_req(stall_req), .halt_seen(halt_seen), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic obs_t observe();
        return {ex_valid, ex_pc, ex_rdat1, ex_rdat2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_aluop, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_halt,
                halt_seen, bubble_cnt};
    endfunction

    function automatic obs_t exp_load(input instr_t i, input logic hs, input int cnt);
        instr_t q = i;
        q.regwrite = i.regwrite & i.valid;
        q.memread  = i.memread  & i.valid;
        q.memwrite = i.memwrite & i.valid;
        q.halt     = i.halt     & i.valid;
        return {q, hs, CNT_W'(cnt)};
    endfunction

    function automatic obs_t exp_bubble(input logic hs, input int cnt);
        instr_t z = '0;
        return {z, hs, CNT_W'(cnt)};
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = 1'b1;
        i.pc       = $urandom;
        i.rdat1    = $urandom;
        i.rdat2    = $urandom;
        i.imm      = $urandom;
        i.rs1      = regbits_t'($urandom_range(0, 31));
        i.rs2      = regbits_t'($urandom_range(0, 31));
        i.rd       = regbits_t'($urandom_range(0, 31));
        i.aluop    = aluop_t'($urandom_range(0, 15));
        i.alusrc   = 1'($urandom_range(0, 1));
        i.regwrite = 1'($urandom_range(0, 1));
        i.memread  = 1'b0;
        i.memwrite = 1'($urandom_range(0, 1));
        i.halt     = 1'b0;
        return i;
    endfunction

    function automatic instr_t mk_lw(input regbits_t rd);
        instr_t i = rand_instr();
        i.memread  = 1'b1;
        i.memwrite = 1'b0;
        i.regwrite = 1'b1;
        i.rd       = rd;
        i.rs1      = 5'd1;
        i.rs2      = 5'd2;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic h, input logic f);
        id_valid = i.valid;    id_pc = i.pc;          id_rdat1 = i.rdat1;
        id_rdat2 = i.rdat2;    id_imm = i.imm;        id_rs1 = i.rs1;
        id_rs2 = i.rs2;        id_rd = i.rd;          id_aluop = i.aluop;
        id_alusrc = i.alusrc;  id_regwrite = i.regwrite;
        id_memread = i.memread; id_memwrite = i.memwrite; id_halt = i.halt;
        hold = h;
        flush = f;
    endtask

    task automatic push(input obs_t e);
        sb.push_back(e);
        last_exp = e;
    endtask

    task automatic bump();
        if (exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (observe() !== '0 || stall_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %h stall=%b want all zero", observe(), stall_req);
        end
        @(negedge CLK);
        RST = 1'b0;
        exp_cnt = 0;
        exp_hs = 1'b0;
        last_exp = '0;
    endtask

    task automatic test_load();
        instr_t a = '0;
        a.valid = 1'b1; a.rs1 = 5'd3; a.rd = 5'd5; a.regwrite = 1'b1;
        a.pc = 32'h100; a.rs2 = 5'd4; a.aluop = 4'd2; a.imm = 32'h10;
        @(negedge CLK); drive(a, 1'b0, 1'b0); push(exp_load(a, exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL load_basic: got %h want %h", got, want);
        end
        n_cmp++;
        if ({ex_valid, ex_regwrite, ex_rs1, ex_rd} !== {1'b1, 1'b1, 5'd3, 5'd5}) begin
            n_bad++;
            $display("FAIL load_fields: got v=%b rw=%b rs1=%0d rd=%0d want 1 1 3 5",
                     ex_valid, ex_regwrite, ex_rs1, ex_rd);
        end
        for (int k = 0; k < 5; k++) begin
            instr_t r = rand_instr();
            if (k == 4) begin
                r.valid = 1'b0; r.alusrc = 1'b0; r.regwrite = 1'b1;
                r.memread = 1'b1; r.memwrite = 1'b1; r.halt = 1'b1;
            end
            @(negedge CLK); drive(r, 1'b0, 1'b0); push(exp_load(r, exp_hs, exp_cnt));
            @(posedge CLK); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL load_rand[%0d]: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        instr_t lw = mk_lw(5'd7);
        instr_t c  = rand_instr();
        c.rs1 = 5'd1; c.rs2 = 5'd7; c.rd = 5'd8; c.regwrite = 1'b1;
        @(negedge CLK); drive(lw, 1'b0, 1'b0); push(exp_load(lw, exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL lu_load: got %h want %h", got, want);
        end
        @(negedge CLK); drive(c, 1'b0, 1'b0); #1;
        n_cmp++;
        if (stall_req !== 1'b1) begin
            n_bad++; $display("FAIL lu_stall_req: got %b want 1", stall_req);
        end
        bump(); push(exp_bubble(exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL lu_bubble: got %h want %h", got, want);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_bad++; $display("FAIL lu_stall_clear: got %b want 0", stall_req);
        end
        push(exp_load(c, exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL lu_reissue: got %h want %h", got, want);
        end
    endtask

    task automatic test_no_hazard();
        for (int k = 0; k < 2; k++) begin
            instr_t lw = mk_lw(k == 0 ? 5'd0 : 5'd9);
            instr_t d  = rand_instr();
            d.rs1 = (k == 0) ? 5'd0 : 5'd9;
            d.rs2 = (k == 0) ? 5'd0 : 5'd9;
            d.valid = (k == 0);
            @(negedge CLK); drive(lw, 1'b0, 1'b0); push(exp_load(lw, exp_hs, exp_cnt));
            @(posedge CLK); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL nh_load[%0d]: got %h want %h", k, got, want);
            end
            @(negedge CLK); drive(d, 1'b0, 1'b0); #1;
            n_cmp++;
            if (stall_req !== 1'b0) begin
                n_bad++; $display("FAIL nh_stall_req[%0d]: got %b want 0", k, stall_req);
            end
            push(exp_load(d, exp_hs, exp_cnt));
            @(posedge CLK); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL nh_next[%0d]: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_flush_hold();
        instr_t lw = mk_lw(5'd6);
        instr_t c  = rand_instr();
        instr_t f  = rand_instr();
        c.rs1 = 5'd6;
        @(negedge CLK); drive(lw, 1'b0, 1'b0); push(exp_load(lw, exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL fh_load: got %h want %h", got, want);
        end
        // 0-2: hold+flush frozen, 3: pending flush bubble, 4: reissue,
        // 5: plain flush, 6: hold only, 7: load after hold
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            case (k)
                0, 1, 2: begin drive(c, 1'b1, 1'b1); push(last_exp); end
                3: begin drive(c, 1'b0, 1'b0); bump(); push(exp_bubble(exp_hs, exp_cnt)); end
                4: begin drive(c, 1'b0, 1'b0); push(exp_load(c, exp_hs, exp_cnt)); end
                5: begin drive(f, 1'b0, 1'b1); bump(); push(exp_bubble(exp_hs, exp_cnt)); end
                6: begin drive(f, 1'b1, 1'b0); push(last_exp); end
                default: begin drive(f, 1'b0, 1'b0); push(exp_load(f, exp_hs, exp_cnt)); end
            endcase
            @(posedge CLK); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL flush_hold[%0d]: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 40; k++) begin
            instr_t lw = mk_lw(5'd9);
            instr_t c  = rand_instr();
            c.rs1 = 5'd9;
            @(negedge CLK);
            if (k % 2 == 0) begin
                drive(lw, 1'b0, 1'b0); push(exp_load(lw, exp_hs, exp_cnt));
            end else begin
                drive(c, 1'b0, 1'b0); bump(); push(exp_bubble(exp_hs, exp_cnt));
            end
            @(posedge CLK); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL sat[%0d]: got %h want %h", k, got, want);
            end
        end
        n_cmp++;
        if (bubble_cnt !== 4'd15) begin
            n_bad++; $display("FAIL sat_final: got %0d want 15", bubble_cnt);
        end
    endtask

    task automatic test_async_reset();
        instr_t a = rand_instr();
        instr_t r = rand_instr();
        @(negedge CLK); drive(a, 1'b1, 1'b1); push(last_exp);
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL ar_hold: got %h want %h", got, want);
        end
        #1 RST = 1'b1;
        #1;
        n_cmp++;
        if (observe() !== '0) begin
            n_bad++; $display("FAIL ar_immediate: got %h want all zero", observe());
        end
        @(negedge CLK);
        RST = 1'b0;
        exp_cnt = 0;
        exp_hs = 1'b0;
        drive(r, 1'b0, 1'b0); push(exp_load(r, exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL ar_first_load: got %h want %h", got, want);
        end
    endtask

    task automatic test_halt();
        instr_t h = rand_instr();
        h.halt = 1'b1;
        // 0: halt load, 1-3: halted bubbles, 4: flush counts, 5: hold frozen
        for (int k = 0; k < 6; k++) begin
            instr_t n = rand_instr();
            n.regwrite = 1'b1;
            @(negedge CLK);
            case (k)
                0: begin drive(h, 1'b0, 1'b0); exp_hs = 1'b1; push(exp_load(h, exp_hs, exp_cnt)); end
                4: begin drive(n, 1'b0, 1'b1); bump(); push(exp_bubble(exp_hs, exp_cnt)); end
                5: begin drive(n, 1'b1, 1'b0); push(last_exp); end
                default: begin drive(n, 1'b0, 1'b0); push(exp_bubble(exp_hs, exp_cnt)); end
            endcase
            @(posedge CLK); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL halt[%0d]: got %h want %h", k, got, want);
            end
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_cmp++;
        if (observe() !== '0) begin
            n_bad++; $display("FAIL halt_reset: got %h want all zero", observe());
        end
        @(negedge CLK);
        RST = 1'b0;
        exp_cnt = 0;
        exp_hs = 1'b0;
        h = rand_instr();
        drive(h, 1'b0, 1'b0); push(exp_load(h, exp_hs, exp_cnt));
        @(posedge CLK); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL halt_post_reset: got %h want %h", got, want);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_cnt = 0;
        exp_hs = 1'b0;
        last_exp = '0;
        RST = 1'b1;
        drive('0, 1'b0, 1'b0);
        test_reset();
        test_load();
        test_load_use();
        test_no_hazard();
        test_flush_hold();
        test_saturation();
        test_async_reset();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
